fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch front-end definitions: widths, reset PC, PC step, PC/instruction pair.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO (DEPTH x WIDTH) with synchronous clear; registered storage, no bypass.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; clear drops every entry at once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generator, in-order imem port,
// instruction buffer toward decode, flush/redirect handling.
// Optional macro FETCH_STATS_EN adds saturating flushCount/dropTotal counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flushReset,
  input  logic [XLEN-1:0] redirectPc,
  output logic            imemReqValid,
  input  logic            imemReqReady,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemRespValid,
  input  logic [XLEN-1:0] imemRespData,
  output logic            instValid,
  input  logic            instReady,
  output logic [XLEN-1:0] instData,
  output logic [XLEN-1:0] instPc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]     flushCount,
  output logic [15:0]     dropTotal
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] headPc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   dropCount;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   credit_used;
  logic            flush;
  logic            req_fire;
  logic            resp_take;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;

  assign flush            = flushReset & ~reset;
  assign redirect_aligned = redirectPc & ~XLEN'(3);

  // In-flight requests and buffered entries share one credit pool of DEPTH.
  assign credit_used  = outstanding + occupancy;
  assign imemReqValid = (credit_used < CW'(DEPTH)) & ~flushReset & ~reset;
  assign imemReqAddr  = fetchPc;
  assign req_fire     = imemReqValid & imemReqReady;

  assign resp_take = imemRespValid & (outstanding != '0);
  assign push      = imemRespValid & ~flush & (dropCount == '0);
  assign pop       = instValid & instReady;

  // dropCount on a flush must see this cycle's request and response updates.
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_take);

  assign instValid = ~fifo_empty;
  assign instPc    = headPc;

  // PC, outstanding and drop tracking; flush redirects both PCs.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      headPc      <= RESET_PC;
      outstanding <= '0;
      dropCount   <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (flush) begin
        fetchPc   <= redirect_aligned;
        headPc    <= redirect_aligned;
        dropCount <= outstanding_next;
      end else begin
        if (req_fire) fetchPc <= fetchPc + XLEN'(PC_INC);
        if (pop)      headPc  <= headPc + XLEN'(PC_INC);
        if (imemRespValid && dropCount != '0) dropCount <= dropCount - 1'b1;
      end
    end
  end

  // Credit rule guarantees a free slot for every accepted response.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && fifo_full));
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (imemRespData),
    .pop       (pop),
    .pop_data  (instData),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

`ifdef FETCH_STATS_EN
  logic resp_drop;
  assign resp_drop = imemRespValid & (flush | (dropCount != '0));

  // Saturating flush-cycle and discarded-response counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      flushCount <= '0;
      dropTotal  <= '0;
    end else begin
      if (flush && flushCount != '1)    flushCount <= flushCount + 1'b1;
      if (resp_drop && dropTotal != '1) dropTotal  <= dropTotal + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus flush sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, flushReset;
  logic [31:0] redirectPc;
  logic        imemReqValid, imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        instValid, instReady;
  logic [31:0] instData, instPc;
`ifdef FETCH_STATS_EN
  logic [15:0] flushCount, dropTotal;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .flushReset    (flushReset),
    .redirectPc    (redirectPc),
    .imemReqValid  (imemReqValid),
    .imemReqReady  (imemReqReady),
    .imemReqAddr   (imemReqAddr),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .instValid     (instValid),
    .instReady     (instReady),
    .instData      (instData),
    .instPc        (instPc)
`ifdef FETCH_STATS_EN
    ,
    .flushCount    (flushCount),
    .dropTotal     (dropTotal)
`endif
  );

  typedef struct {
    logic        rst, flush;
    logic [31:0] redir;
    logic        rdy, rv;
    logic [31:0] rd;
    logic        inrdy;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[17];

  // Memory model content: instruction word derived from its address.
  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hD000_0000 | a;
  endfunction

  function automatic vec_t mk(input logic rst, flush, input logic [31:0] redir,
                              input logic rdy, rv, input logic [31:0] rd, input logic inrdy,
                              input logic e_rqv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_pc, e_data);
    vec_t v;
    v.rst = rst; v.flush = flush; v.redir = redir; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.inrdy = inrdy; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_pc = e_pc; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, flush, input logic [31:0] redir,
                       input logic rdy, rv, input logic [31:0] rd, input logic inrdy);
    reset = rst; flushReset = flush; redirectPc = redir;
    imemReqReady = rdy; imemRespValid = rv; imemRespData = rd; instReady = inrdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Streaming with 1-cycle memory, then a mid-stream reset, then decode back-pressure.
    vt[0]  = mk(1,1,0, 1,0,0,         1, 0,32'h0, 0,32'h0,0);
    vt[1]  = mk(0,0,0, 1,0,0,         1, 1,32'h0, 0,32'h0,0);
    vt[2]  = mk(0,0,0, 1,1,dat(32'h0),1, 1,32'h4, 0,32'h0,0);
    vt[3]  = mk(0,0,0, 1,1,dat(32'h4),1, 1,32'h8, 1,32'h0,dat(32'h0));
    vt[4]  = mk(0,0,0, 1,1,dat(32'h8),1, 1,32'hC, 1,32'h4,dat(32'h4));
    vt[5]  = mk(0,0,0, 1,1,dat(32'hC),1, 1,32'h10,1,32'h8,dat(32'h8));
    vt[6]  = mk(1,1,0, 1,0,0,         1, 0,32'h0, 1,32'hC,dat(32'hC));
    vt[7]  = mk(0,0,0, 1,0,0,         0, 1,32'h0, 0,32'h0,0);
    vt[8]  = mk(0,0,0, 1,1,dat(32'h0),0, 1,32'h4, 0,32'h0,0);
    vt[9]  = mk(0,0,0, 1,1,dat(32'h4),0, 1,32'h8, 1,32'h0,dat(32'h0));
    vt[10] = mk(0,0,0, 1,1,dat(32'h8),0, 1,32'hC, 1,32'h0,dat(32'h0));
    vt[11] = mk(0,0,0, 1,1,dat(32'hC),0, 0,32'h0, 1,32'h0,dat(32'h0));
    vt[12] = mk(0,0,0, 1,0,0,         0, 0,32'h0, 1,32'h0,dat(32'h0));
    vt[13] = mk(0,0,0, 1,0,0,         1, 0,32'h0, 1,32'h0,dat(32'h0));
    vt[14] = mk(0,0,0, 1,0,0,         0, 1,32'h10,1,32'h4,dat(32'h4));
    vt[15] = mk(0,0,0, 1,1,dat(32'h10),1,0,32'h0, 1,32'h4,dat(32'h4));
    vt[16] = mk(0,0,0, 1,0,0,         1, 1,32'h14,1,32'h8,dat(32'h8));

    drive(1,1,0, 1,0,0, 1);
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].flush, vt[i].redir, vt[i].rdy, vt[i].rv, vt[i].rd, vt[i].inrdy);
      #1;
      chk($sformatf("v%0d_reqValid", i), 32'(imemReqValid), 32'(vt[i].e_rqv));
      if (vt[i].e_rqv) chk($sformatf("v%0d_reqAddr", i), imemReqAddr, vt[i].e_addr);
      chk($sformatf("v%0d_instValid", i), 32'(instValid), 32'(vt[i].e_iv));
      chk($sformatf("v%0d_instPc", i), instPc, vt[i].e_pc);
      if (vt[i].e_iv || vt[i].rst) chk($sformatf("v%0d_instData", i), instData, vt[i].e_data);
      tick();
    end

    // Flush with two requests outstanding: both late responses must be dropped.
    drive(1,1,0, 1,0,0, 1); #1; tick();
    drive(0,0,0, 1,0,0, 1); #1; chk("c1_addr", imemReqAddr, 32'h0); tick();
    drive(0,0,0, 1,0,0, 1); #1; chk("c2_addr", imemReqAddr, 32'h4); tick();
    drive(0,1,32'h100, 1,0,0, 1); #1; chk("c3_flush_reqValid", 32'(imemReqValid), 0); tick();
    drive(0,0,0, 0,1,dat(32'h0), 1); #1;
    chk("c4_reqValid", 32'(imemReqValid), 1); chk("c4_addr", imemReqAddr, 32'h100); tick();
    drive(0,0,0, 0,1,dat(32'h4), 1); #1; chk("c5_instValid", 32'(instValid), 0); tick();
    drive(0,0,0, 1,0,0, 1); #1;
    chk("c6_instValid", 32'(instValid), 0); chk("c6_addr", imemReqAddr, 32'h100); tick();
    drive(0,0,0, 0,1,dat(32'h100), 1); #1; chk("c7_instValid", 32'(instValid), 0); tick();
    drive(0,0,0, 0,0,0, 1); #1;
    chk("c8_instValid", 32'(instValid), 1); chk("c8_instPc", instPc, 32'h100);
    chk("c8_instData", instData, dat(32'h100)); tick();

    // Flush coinciding with a response and a pop; redirect low bits ignored.
    drive(0,0,0, 1,0,0, 0); #1; chk("d1_addr", imemReqAddr, 32'h104); tick();
    drive(0,0,0, 1,1,dat(32'h104), 0); #1; chk("d2_addr", imemReqAddr, 32'h108); tick();
    drive(0,0,0, 1,0,0, 0); #1;
    chk("d3_addr", imemReqAddr, 32'h10C); chk("d3_instPc", instPc, 32'h104); tick();
    drive(0,1,32'h203, 1,1,dat(32'h108), 1); #1;
    chk("d4_flush_reqValid", 32'(imemReqValid), 0);
    chk("d4_instValid", 32'(instValid), 1); chk("d4_instPc", instPc, 32'h104);
    chk("d4_instData", instData, dat(32'h104)); tick();
    drive(0,0,0, 0,1,dat(32'h10C), 1); #1;
    chk("d5_instValid", 32'(instValid), 0); chk("d5_reqValid", 32'(imemReqValid), 1);
    chk("d5_addr", imemReqAddr, 32'h200); chk("d5_instPc", instPc, 32'h200); tick();
    drive(0,0,0, 1,0,0, 1); #1;
    chk("d6_instValid", 32'(instValid), 0); chk("d6_addr", imemReqAddr, 32'h200); tick();
    drive(0,0,0, 0,1,dat(32'h200), 1); #1; chk("d7_instValid", 32'(instValid), 0); tick();
    drive(0,0,0, 0,0,0, 1); #1;
    chk("d8_instValid", 32'(instValid), 1); chk("d8_instPc", instPc, 32'h200);
    chk("d8_instData", instData, dat(32'h200)); tick();

    // Back-to-back flushes: the later redirect wins.
    drive(0,1,32'h300, 1,0,0, 1); #1; chk("e1_reqValid", 32'(imemReqValid), 0); tick();
    drive(0,1,32'h400, 1,0,0, 1); #1; chk("e2_reqValid", 32'(imemReqValid), 0); tick();
    drive(0,0,0, 1,0,0, 1); #1;
    chk("e3_reqValid", 32'(imemReqValid), 1); chk("e3_addr", imemReqAddr, 32'h400); tick();
    drive(0,0,0, 1,1,dat(32'h400), 1); #1; chk("e4_addr", imemReqAddr, 32'h404); tick();
    drive(0,0,0, 0,1,dat(32'h404), 1); #1;
    chk("e5_instValid", 32'(instValid), 1); chk("e5_instPc", instPc, 32'h400);
    chk("e5_instData", instData, dat(32'h400)); tick();
    drive(0,0,0, 0,0,0, 1); #1;
    chk("e6_instPc", instPc, 32'h404); chk("e6_instData", instData, dat(32'h404)); tick();

`ifdef FETCH_STATS_EN
    // Since the last reset: flush cycles c3,d4,e1,e2; dropped responses c4,c5,d4,d5.
    chk("stats_flushCount", 32'(flushCount), 4);
    chk("stats_dropTotal", 32'(dropTotal), 4);
    drive(1,1,0, 1,0,0, 1); #1; tick();
    chk("stats_flushCount_rst", 32'(flushCount), 0);
    chk("stats_dropTotal_rst", 32'(dropTotal), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
